// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor, adder, comparator).
package serial_arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} ser_state_t;

endpackage

// File: rtl/sub_one_bit.sv
// One-bit full subtractor cell: diff = a - b - bin, with borrow out.
module sub_one_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: a - b, one bit per clock, LSB first,
// valid/ready handshake on input and output.
module serial_sub
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, diff_sh_q, diff_q;
    logic [WIDTH-1:0] diff_sh_next;
    logic [CW-1:0]    count_q;
    logic             borrow_q, bout_q, ovf_q, a_msb_q, b_msb_q;
    logic             cell_diff, cell_bout;

    sub_one_bit u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    assign diff_sh_next = {cell_diff, diff_sh_q[WIDTH-1:1]};

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~reset;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (count_q == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            diff_q    <= '0;
            count_q   <= '0;
            borrow_q  <= 1'b0;
            bout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                    end
                end
                RUN: begin
                    a_sh_q    <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q    <= {1'b0, b_sh_q[WIDTH-1:1]};
                    diff_sh_q <= diff_sh_next;
                    borrow_q  <= cell_bout;
                    count_q   <= count_q + CW'(1);
                    // Result registers load on the final bit so they hold through IDLE.
                    if (count_q == LAST) begin
                        diff_q <= diff_sh_next;
                        bout_q <= cell_bout;
                        ovf_q  <= (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
